logic_unit_seq: RTL and testbench

- Parametrised, multi-cycle bitwise logic unit; successor to the fixed 32-bit single-function logic gates in the CPU datapath.
- Computes one of eight bitwise functions of two WIDTH-bit operands, SLICE bits per clock.
- Uses a start/done handshake, so the execute stage can share one small logic slice across wide operands.
- Produces the result and a zero flag, both held stable until the next accepted operation.

---
 rtl/logic_unit_seq.sv | 143 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit.
// One shared SLICE-bit logic slice is walked across WIDTH-bit operands,
// producing one slice per clock. A start/done handshake is used. res and
// zero hold until the next accepted operation.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while ready=1
//   op     - function select (AND/OR/XOR/NOR/NAND/XNOR/ANDN/ORN), sampled with start
//   A, B   - operands, sampled with start
//   abort  - synchronous cancel, effective only while busy
//   ready  - unit can accept start (IDLE or DONE)
//   busy   - operation in progress (RUN)
//   done   - one-cycle pulse when res is complete
//   res    - result register
//   zero   - res == 0, valid with done and held afterwards

// Combinational SLICE-bit logic function, shared across all slices.
module logic_slice #(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b010: y = a ^ b;
            3'b011: y = ~(a | b);
            3'b100: y = ~(a & b);
            3'b101: y = ~(a ^ b);
            3'b110: y = a & ~b;
            3'b111: y = a | ~b;
            default: y = '0;
        endcase
    end
endmodule

module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    // Operands and result viewed as NSLICE slices so the counter indexes directly.
    logic [NSLICE-1:0][SLICE-1:0] a_q, b_q, res_q, res_wr;
    logic [2:0]    op_q;
    logic [CW-1:0] cnt;
    logic          zero_q;
    logic [SLICE-1:0] slice_y;
    logic          accept, last;

    // DONE accepts a start exactly like IDLE, giving back-to-back operation.
    assign accept = start && (state != S_RUN);
    assign last   = (cnt == LAST);

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .a  (a_q[cnt]),
        .b  (b_q[cnt]),
        .y  (slice_y)
    );

    // Result with the current slice merged in; also feeds the zero test so the
    // final slice is included in the flag.
    always_comb begin
        res_wr      = res_q;
        res_wr[cnt] = slice_y;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = accept ? S_RUN : S_IDLE;
            S_RUN: begin
                if (abort)     state_nxt = S_IDLE;   // abort beats the final slice
                else if (last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            res_q <= '0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            if (abort) begin
                // Partial result is kept; only the flag is invalidated.
                zero_q <= 1'b0;
            end else begin
                res_q <= res_wr;
                cnt   <= last ? '0 : cnt + 1'b1;
                if (last) zero_q <= (res_wr == '0);
            end
        end
    end

    assign ready = (state != S_RUN);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);
    assign res   = res_q;
    assign zero  = zero_q;
endmodule

// File: tb/tb_logic_unit_seq.sv
module tb_logic_unit_seq;
    localparam int W = 32;
    localparam int S = 8;
    localparam int N = W / S;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance (32/8)
    logic         start, abort, ready, busy, done, zero;
    logic [2:0]   op;
    logic [W-1:0] a, b, res;

    logic_unit_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
        .abort(abort), .ready(ready), .busy(busy), .done(done), .res(res), .zero(zero));

    // Variant 64/16
    logic        v1_start, v1_abort, v1_ready, v1_busy, v1_done, v1_zero;
    logic [2:0]  v1_op;
    logic [63:0] v1_a, v1_b, v1_res;
    logic_unit_seq #(.WIDTH(64), .SLICE(16)) dut_v1 (
        .clk(clk), .rst_n(rst_n), .start(v1_start), .op(v1_op), .A(v1_a), .B(v1_b),
        .abort(v1_abort), .ready(v1_ready), .busy(v1_busy), .done(v1_done), .res(v1_res), .zero(v1_zero));

    // Variant 8/8
    logic        v2_start, v2_abort, v2_ready, v2_busy, v2_done, v2_zero;
    logic [2:0]  v2_op;
    logic [7:0]  v2_a, v2_b, v2_res;
    logic_unit_seq #(.WIDTH(8), .SLICE(8)) dut_v2 (
        .clk(clk), .rst_n(rst_n), .start(v2_start), .op(v2_op), .A(v2_a), .B(v2_b),
        .abort(v2_abort), .ready(v2_ready), .busy(v2_busy), .done(v2_done), .res(v2_res), .zero(v2_zero));

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Behavioural model: whole-word function, result revealed k slices at a time.
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;
    int           ph = PH_IDLE;
    int           k;
    logic [W-1:0] m_full, m_res;
    logic         m_zero;

    function automatic logic [W-1:0] fn(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x | y);
            3'd4: return ~(x & y);
            3'd5: return ~(x ^ y);
            3'd6: return x & ~y;
            default: return x | ~y;
        endcase
    endfunction

    function automatic logic [W-1:0] low_mask(input int nsl);
        logic [63:0] t;
        t = (64'd1 << (nsl * S)) - 64'd1;
        return t[W-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = PH_IDLE; k = 0; m_res = '0; m_zero = 1'b0;
        end else if (ph == PH_RUN) begin
            if (abort) begin
                ph = PH_IDLE; m_zero = 1'b0;
            end else begin
                k++;
                m_res = m_full & low_mask(k);
                if (k == N) begin
                    m_zero = (m_full == '0);
                    ph = PH_DONE;
                end
            end
        end else if (start) begin
            m_full = fn(op, a, b); k = 0; m_res = '0; ph = PH_RUN;
        end else begin
            ph = PH_IDLE;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(ready), 64'(ph != PH_RUN));
            check("busy",  64'(busy),  64'(ph == PH_RUN));
            check("done",  64'(done),  64'(ph == PH_DONE));
            check("res",   64'(res),   64'(m_res));
            check("zero",  64'(zero),  64'(m_zero));
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_res, input logic exp_zero, input string nm);
        int n;
        @(negedge clk); start = 1'b1; op = o; a = x; b = y;
        @(negedge clk); start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check({nm, "_lat"},  64'(n), 64'(N));
        check({nm, "_res"},  64'(res), 64'(exp_res));
        check({nm, "_zero"}, 64'(zero), 64'(exp_zero));
    endtask

    task automatic abort_at(input int m, input logic [W-1:0] exp_res, input string nm);
        int pulses;
        @(negedge clk); start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0;
        @(negedge clk); start = 1'b0;
        repeat (m - 1) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check({nm, "_ready"}, 64'(ready), 64'd1);
        check({nm, "_busy"},  64'(busy),  64'd0);
        check({nm, "_zero"},  64'(zero),  64'd0);
        check({nm, "_res"},   64'(res),   64'(exp_res));
        pulses = 0;
        repeat (6) begin @(negedge clk); if (done) pulses++; end
        check({nm, "_nodone"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] sweep [8];
        int first, second, v1n, v2n;
        logic [63:0] v1r;
        logic [7:0]  v2r;
        sweep = '{32'h05A0_05A0, 32'hAFF5_AFF5, 32'hAA55_AA55, 32'h500A_500A,
                  32'hFA5F_FA5F, 32'h55AA_55AA, 32'hA005_A005, 32'hF5AF_F5AF};
        start = 0; abort = 0; op = 0; a = 0; b = 0;
        v1_start = 0; v1_abort = 0; v1_op = 0; v1_a = 0; v1_b = 0;
        v2_start = 0; v2_abort = 0; v2_op = 0; v2_a = 0; v2_b = 0;

        // Asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_res",   64'(res),   64'd0);
        check("rst_zero",  64'(zero),  64'd0);
        check("rst_v1_ready", 64'(v1_ready), 64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; chk_en = 1'b1;

        run_op(3'b011, 32'h0F0F_0000, 32'h00F0_0000, 32'hF000_FFFF, 1'b0, "nor1");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "nor_zero");
        for (int i = 0; i < 8; i++)
            run_op(3'(i), 32'hA5A5_A5A5, 32'h0FF0_0FF0, sweep[i], 1'b0, $sformatf("sweep%0d", i));

        // Aborts: third RUN edge, then final RUN edge; zero was 1 before each
        abort_at(3, 32'h0000_FFFF, "abort3");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, "nor_zero2");
        abort_at(4, 32'h00FF_FFFF, "abort4");
        run_op(3'b010, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, "after_abort");

        // Back-to-back with start held and operands churning; abort in DONE is ignored
        @(negedge clk); start = 1'b1; op = 3'b000; a = 32'hA5A5_A5A5; b = 32'h0FF0_0FF0;
        first = -1; second = -1;
        for (int i = 1; i <= 20 && second < 0; i++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) begin
                    first = i;
                    check("b2b_res1", 64'(res), 64'h05A0_05A0);
                    abort = 1'b1;
                end else second = i;
            end else abort = 1'b0;
            a = $urandom; b = $urandom;
        end
        start = 1'b0; abort = 1'b0;
        check("b2b_first", 64'(first), 64'(N + 1));
        check("b2b_gap",   64'(second - first), 64'(N + 1));

        // Randomized traffic against the model
        repeat (800) begin
            @(negedge clk);
            start = ($urandom % 3 == 0);
            abort = ($urandom % 6 == 0);
            op = 3'($urandom); a = $urandom; b = $urandom;
        end
        @(negedge clk); start = 1'b0; abort = 1'b0;
        repeat (8) @(negedge clk);

        // Reset while running
        @(negedge clk); start = 1'b1; op = 3'b001; a = 32'hDEAD_BEEF; b = 32'h0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstrun_busy",  64'(busy),  64'd0);
        check("rstrun_ready", 64'(ready), 64'd1);
        check("rstrun_res",   64'(res),   64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Parameter variants
        @(negedge clk);
        v1_start = 1'b1; v1_op = 3'b010; v1_a = 64'hFFFF_0000_FFFF_0000; v1_b = 64'h0000_FFFF_FFFF_0000;
        v2_start = 1'b1; v2_op = 3'b000; v2_a = 8'h3C; v2_b = 8'hF0;
        @(negedge clk); v1_start = 1'b0; v2_start = 1'b0;
        v1n = -1; v2n = -1; v1r = '0; v2r = '0;
        for (int n = 1; n <= 20 && (v1n < 0 || v2n < 0); n++) begin
            @(negedge clk);
            if (v1_done && v1n < 0) begin v1n = n; v1r = v1_res; end
            if (v2_done && v2n < 0) begin v2n = n; v2r = v2_res; end
        end
        check("v1_lat",  64'(v1n), 64'd4);
        check("v1_res",  v1r, 64'hFFFF_FFFF_0000_0000);
        check("v1_zero", 64'(v1_zero), 64'd0);
        check("v2_lat",  64'(v2n), 64'd1);
        check("v2_res",  64'(v2r), 64'h30);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
